// File: rtl/seller_pkg.sv
// rtl/seller_pkg.sv - money units and prices shared by the coin accumulator and the seller controller
package seller_pkg;

    localparam int MONEY_W       = 8;
    localparam int RMB1_UNITS    = 2;
    localparam int RMB10_UNITS   = 20;
    localparam int PRICE25_UNITS = 5;
    localparam int PRICE5_UNITS  = 10;

endpackage

// File: rtl/coin_accumulator_if.sv
// rtl/coin_accumulator_if.sv - coin buttons, controller strobes and credit outputs of the accumulator
interface coin_accumulator_if;
    import seller_pkg::*;

    logic               rmb1;
    logic               rmb10;
    logic               accurst;
    logic               acculock;
    logic [MONEY_W-1:0] money;
    logic               coin_evt;
    logic               overflow;

    modport master (
        output rmb1, rmb10, accurst, acculock,
        input  money, coin_evt, overflow
    );

    modport slave (
        input  rmb1, rmb10, accurst, acculock,
        output money, coin_evt, overflow
    );

endinterface

// File: rtl/coin_filter.sv
// rtl/coin_filter.sv - per-button sync, optional debounce (ACCU_DEBOUNCE_EN), arming and rise pulse
module coin_filter
`ifdef ACCU_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DB_CNT_W        = 16
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic rise_o
);

    logic [1:0] sync_q;
    logic [1:0] vld_q;
    logic       f_q;
    logic       fd_q;
    logic       armed_q;
    logic       s;

    assign s = sync_q[1];

`ifdef ACCU_DEBOUNCE_EN
    logic [DB_CNT_W-1:0] cnt_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            vld_q   <= '0;
            f_q     <= 1'b0;
            fd_q    <= 1'b0;
            armed_q <= 1'b0;
`ifdef ACCU_DEBOUNCE_EN
            cnt_q   <= '0;
`endif
        end else begin
            sync_q <= {sync_q[0], btn_i};
            vld_q  <= {vld_q[0], 1'b1};
            fd_q   <= f_q;
            // Reset zeros in the sync chain are not proof the button was released.
            if (vld_q[1] && !s && !f_q) begin
                armed_q <= 1'b1;
            end
`ifdef ACCU_DEBOUNCE_EN
            if (s != f_q) begin
                if (cnt_q == DB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    f_q   <= s;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
`else
            f_q <= s;
`endif
        end
    end

    assign rise_o = f_q & ~fd_q & armed_q;

endmodule

// File: rtl/coin_accumulator.sv
// rtl/coin_accumulator.sv - saturating coin credit total; ACCU_DEBOUNCE_EN enables button debouncing
module coin_accumulator
    import seller_pkg::*;
#(
    parameter int MONEY_MAX       = 255
`ifdef ACCU_DEBOUNCE_EN
   ,parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DB_CNT_W        = 16
`endif
)
(
    input  logic              clk,
    input  logic              rst_n,
    coin_accumulator_if.slave bus
);

    localparam int SUM_W = MONEY_W + 2;

    logic               rise1;
    logic               rise10;
    logic [MONEY_W-1:0] money_q, money_d;
    logic               evt_q, evt_d;
    logic               ovf_q, ovf_d;
    logic [SUM_W-1:0]   add_w;
    logic [SUM_W-1:0]   sum_w;

`ifdef ACCU_DEBOUNCE_EN
    coin_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_CNT_W(DB_CNT_W))
        u_f1  (.clk(clk), .rst_n(rst_n), .btn_i(bus.rmb1),  .rise_o(rise1));
    coin_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_CNT_W(DB_CNT_W))
        u_f10 (.clk(clk), .rst_n(rst_n), .btn_i(bus.rmb10), .rise_o(rise10));
`else
    coin_filter u_f1  (.clk(clk), .rst_n(rst_n), .btn_i(bus.rmb1),  .rise_o(rise1));
    coin_filter u_f10 (.clk(clk), .rst_n(rst_n), .btn_i(bus.rmb10), .rise_o(rise10));
`endif

    assign add_w = (rise1  ? SUM_W'(RMB1_UNITS)  : '0)
                 + (rise10 ? SUM_W'(RMB10_UNITS) : '0);
    assign sum_w = {2'b00, money_q} + add_w;

    // Edges seen during clear or lock are dropped; the rise pulse is one cycle so nothing is queued.
    always_comb begin
        money_d = money_q;
        evt_d   = 1'b0;
        ovf_d   = ovf_q;
        if (bus.accurst) begin
            money_d = '0;
            ovf_d   = 1'b0;
        end else if (!bus.acculock && add_w != '0) begin
            evt_d = 1'b1;
            if (sum_w > SUM_W'(MONEY_MAX)) begin
                money_d = MONEY_W'(MONEY_MAX);
                ovf_d   = 1'b1;
            end else begin
                money_d = sum_w[MONEY_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            money_q <= '0;
            evt_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            money_q <= money_d;
            evt_q   <= evt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.money    = money_q;
    assign bus.coin_evt = evt_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_coin_accumulator.sv
// tb/tb_coin_accumulator.sv - directed self-checking bench for coin_accumulator
module tb_coin_accumulator;
    import seller_pkg::*;

`ifdef ACCU_DEBOUNCE_EN
    localparam int LAT = 11, HOLD = 12, GAP = 16;
`else
    localparam int LAT = 4, HOLD = 5, GAP = 6;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    coin_accumulator_if bus();

`ifdef ACCU_DEBOUNCE_EN
    coin_accumulator #(.MONEY_MAX(255), .DEBOUNCE_CYCLES(8), .DB_CNT_W(16))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
    coin_accumulator #(.MONEY_MAX(255))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    int total = 0;
    int bad = 0;
    int evt_seen = 0;

    task automatic step();
        @(negedge clk);
        if (bus.coin_evt) evt_seen++;
    endtask

    task automatic press(input logic b1, input logic b10);
        bus.rmb1  = b1;
        bus.rmb10 = b10;
        repeat (HOLD) step();
        bus.rmb1  = 1'b0;
        bus.rmb10 = 1'b0;
        repeat (GAP) step();
    endtask

    task automatic clear();
        bus.accurst = 1'b1;
        step();
        bus.accurst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        bus.rmb1 = 0; bus.rmb10 = 0; bus.accurst = 0; bus.acculock = 0;
        rst_n = 1'b0;
        repeat (3) step();
        total++; if (bus.money !== 8'd0) begin bad++; $display("FAIL reset_money got=%0d want=0", bus.money); end
        total++; if (bus.coin_evt !== 1'b0) begin bad++; $display("FAIL reset_evt got=%b want=0", bus.coin_evt); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", bus.overflow); end
        rst_n = 1'b1;
        repeat (5) step();
    endtask

    task automatic test_single_press();
        logic [7:0] exp_m;
        logic       exp_e;
        bus.rmb1 = 1'b1;
        for (int i = 1; i <= LAT + GAP; i++) begin
            step();
            exp_m = (i >= LAT) ? 8'd2 : 8'd0;
            exp_e = (i == LAT);
            total++; if (bus.money !== exp_m) begin bad++; $display("FAIL single_money step=%0d got=%0d want=%0d", i, bus.money, exp_m); end
            total++; if (bus.coin_evt !== exp_e) begin bad++; $display("FAIL single_evt step=%0d got=%b want=%b", i, bus.coin_evt, exp_e); end
            if (i == HOLD) bus.rmb1 = 1'b0;
        end
    endtask

    task automatic test_hold();
        clear();
        total++; if (bus.money !== 8'd0) begin bad++; $display("FAIL hold_clear got=%0d want=0", bus.money); end
        evt_seen = 0;
        press(1'b0, 1'b1);
        total++; if (bus.money !== 8'd20) begin bad++; $display("FAIL hold_rmb10 got=%0d want=20", bus.money); end
        bus.rmb1 = 1'b1;
        repeat (100) step();
        total++; if (bus.money !== 8'd22) begin bad++; $display("FAIL hold_during got=%0d want=22", bus.money); end
        bus.rmb1 = 1'b0;
        repeat (GAP) step();
        total++; if (bus.money !== 8'd22) begin bad++; $display("FAIL hold_after got=%0d want=22", bus.money); end
        total++; if (evt_seen !== 2) begin bad++; $display("FAIL hold_evts got=%0d want=2", evt_seen); end
    endtask

    task automatic test_saturate();
        clear();
        for (int i = 0; i < 12; i++) press(1'b0, 1'b1);
        total++; if (bus.money !== 8'd240) begin bad++; $display("FAIL sat_240 got=%0d want=240", bus.money); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL sat_ovf_pre got=%b want=0", bus.overflow); end
        press(1'b0, 1'b1);
        total++; if (bus.money !== 8'd255) begin bad++; $display("FAIL sat_255 got=%0d want=255", bus.money); end
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL sat_ovf got=%b want=1", bus.overflow); end
        press(1'b1, 1'b0);
        total++; if (bus.money !== 8'd255) begin bad++; $display("FAIL sat_hold got=%0d want=255", bus.money); end
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL sat_ovf_sticky got=%b want=1", bus.overflow); end
        clear();
        total++; if (bus.money !== 8'd0) begin bad++; $display("FAIL sat_clear got=%0d want=0", bus.money); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL sat_ovf_clear got=%b want=0", bus.overflow); end
    endtask

    task automatic test_lock();
        clear();
        evt_seen = 0;
        bus.acculock = 1'b1;
        press(1'b0, 1'b1);
        bus.acculock = 1'b0;
        repeat (GAP) step();
        total++; if (bus.money !== 8'd0) begin bad++; $display("FAIL lock_money got=%0d want=0", bus.money); end
        total++; if (evt_seen !== 0) begin bad++; $display("FAIL lock_evts got=%0d want=0", evt_seen); end
        press(1'b0, 1'b1);
        total++; if (bus.money !== 8'd20) begin bad++; $display("FAIL lock_release got=%0d want=20", bus.money); end
    endtask

    task automatic test_simultaneous();
        clear();
        evt_seen = 0;
        press(1'b1, 1'b1);
        total++; if (bus.money !== 8'd22) begin bad++; $display("FAIL both_money got=%0d want=22", bus.money); end
        total++; if (evt_seen !== 1) begin bad++; $display("FAIL both_evts got=%0d want=1", evt_seen); end
    endtask

    task automatic test_reset_held();
        clear();
        bus.rmb1 = 1'b1;
        repeat (LAT + 2) step();
        total++; if (bus.money !== 8'd2) begin bad++; $display("FAIL rsth_pre got=%0d want=2", bus.money); end
        rst_n = 1'b0;
        #1;
        total++; if (bus.money !== 8'd0) begin bad++; $display("FAIL rsth_async got=%0d want=0", bus.money); end
        repeat (2) step();
        rst_n = 1'b1;
        evt_seen = 0;
        repeat (3 * GAP) step();
        total++; if (bus.money !== 8'd0) begin bad++; $display("FAIL rsth_held got=%0d want=0", bus.money); end
        bus.rmb1 = 1'b0;
        repeat (GAP) step();
        total++; if (bus.money !== 8'd0) begin bad++; $display("FAIL rsth_release got=%0d want=0", bus.money); end
        total++; if (evt_seen !== 0) begin bad++; $display("FAIL rsth_evts got=%0d want=0", evt_seen); end
        press(1'b1, 1'b0);
        total++; if (bus.money !== 8'd2) begin bad++; $display("FAIL rsth_repress got=%0d want=2", bus.money); end
    endtask

`ifdef ACCU_DEBOUNCE_EN
    task automatic test_glitch();
        clear();
        evt_seen = 0;
        bus.rmb1 = 1'b1;
        repeat (5) step();
        bus.rmb1 = 1'b0;
        repeat (20) step();
        total++; if (bus.money !== 8'd0) begin bad++; $display("FAIL glitch_money got=%0d want=0", bus.money); end
        total++; if (evt_seen !== 0) begin bad++; $display("FAIL glitch_evts got=%0d want=0", evt_seen); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_press();
        test_hold();
        test_saturate();
        test_lock();
        test_simultaneous();
        test_reset_held();
`ifdef ACCU_DEBOUNCE_EN
        test_glitch();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
